// File: rtl/kschedule_pkg.sv
// Shared constants and types for the DES key-schedule rotation engine.
package kschedule_pkg;

  localparam int          DES_HALF_W      = 28;
  localparam int          DES_ROUNDS      = 16;
  localparam logic [15:0] DES_SHIFT_SCHED = 16'h7EFC;

  typedef enum logic {
    IDLE,
    RUN
  } ks_state_t;

  typedef enum logic {
    ROT_LEFT,
    ROT_RIGHT
  } rot_dir_t;

endpackage

// File: rtl/kschedule_if.sv
// Command and round-key stream bundle between the key source, the schedule
// engine and the round-key consumer.
interface kschedule_if #(
  parameter int HALF_W = 28,
  parameter int ROUNDS = 16
);

  localparam int RW = $clog2(ROUNDS + 1);

  logic              start;
  logic              decrypt;
  logic [HALF_W-1:0] key_c;
  logic [HALF_W-1:0] key_d;
  logic              busy;
  logic              rk_valid;
  logic              rk_ready;
  logic [HALF_W-1:0] rk_c;
  logic [HALF_W-1:0] rk_d;
  logic [RW-1:0]     rk_round;
  logic              done;

  // Key source / consumer side.
  modport master (
    output start, decrypt, key_c, key_d, rk_ready,
    input  busy, rk_valid, rk_c, rk_d, rk_round, done
  );

  // Schedule engine side.
  modport slave (
    input  start, decrypt, key_c, key_d, rk_ready,
    output busy, rk_valid, rk_c, rk_d, rk_round, done
  );

endinterface

// File: rtl/krotate.sv
// Combinational circular rotate of one key half by 0, 1 or 2 places.
module krotate
  import kschedule_pkg::*;
#(
  parameter int HALF_W = DES_HALF_W
) (
  input  logic [HALF_W-1:0] din,
  input  logic [1:0]        amount,
  input  rot_dir_t          dir,
  output logic [HALF_W-1:0] dout
);

  // Select the rotated word; amount 0 (and the unused code 3) passes through.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    dout = din;
    case (amount)
      2'd1: dout = (dir == ROT_LEFT) ? {din[HALF_W-2:0], din[HALF_W-1]}
                                     : {din[0], din[HALF_W-1:1]};
      2'd2: dout = (dir == ROT_LEFT) ? {din[HALF_W-3:0], din[HALF_W-1:HALF_W-2]}
                                     : {din[1:0], din[HALF_W-1:2]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/kschedule_seq.sv
// Multi-round C/D rotation sequencer: captures a key on start and streams one
// rotated C/D pair per round, in encrypt (left) or decrypt (right) order.
module kschedule_seq
  import kschedule_pkg::*;
#(
  parameter int                HALF_W      = DES_HALF_W,
  parameter int                ROUNDS      = DES_ROUNDS,
  parameter logic [ROUNDS-1:0] SHIFT_SCHED = DES_SHIFT_SCHED
) (
  input logic        clk,
  input logic        rst,
  kschedule_if.slave bus
);

  localparam int            RW         = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS);

  ks_state_t         state_q;
  ks_state_t         state_next;
  logic [HALF_W-1:0] c_q;
  logic [HALF_W-1:0] d_q;
  logic [RW-1:0]     round_q;
  logic              dec_q;
  logic              done_q;

  logic              accept;
  logic              fire;
  logic              last_round;
  logic [RW-1:0]     sched_idx;
  logic              sched_bit;
  logic [HALF_W-1:0] rot_c_in;
  logic [HALF_W-1:0] rot_d_in;
  logic [HALF_W-1:0] rot_c_out;
  logic [HALF_W-1:0] rot_d_out;
  logic [1:0]        rot_amount;
  rot_dir_t          rot_dir;

  assign accept     = (state_q == IDLE) && bus.start;
  assign fire       = (state_q == RUN) && bus.rk_ready;
  assign last_round = (round_q == LAST_ROUND);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_next;
  end

  // Next-state: start leaves IDLE, the handshake on the last round returns.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (bus.rk_ready && last_round) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rotation control: in IDLE prepare round 1 from the key inputs; in RUN
  // prepare round r+1 from the held round-r value. Encrypt round r+1 uses
  // schedule bit r; decrypt round r+1 walks the schedule backwards, bit ROUNDS-r.
  always_comb begin
    sched_idx = dec_q ? (LAST_ROUND - round_q) : round_q;
    sched_bit = 1'b0;
    for (int i = 0; i < ROUNDS; i++) begin
      if (sched_idx == RW'(i)) sched_bit = SHIFT_SCHED[i];
    end
    if (state_q == IDLE) begin
      rot_c_in   = bus.key_c;
      rot_d_in   = bus.key_d;
      rot_dir    = ROT_LEFT;
      rot_amount = bus.decrypt ? 2'd0 : (SHIFT_SCHED[0] ? 2'd2 : 2'd1);
    end else begin
      rot_c_in   = c_q;
      rot_d_in   = d_q;
      rot_dir    = dec_q ? ROT_RIGHT : ROT_LEFT;
      rot_amount = sched_bit ? 2'd2 : 2'd1;
    end
  end

  krotate #(.HALF_W(HALF_W)) u_rot_c (
    .din    (rot_c_in),
    .amount (rot_amount),
    .dir    (rot_dir),
    .dout   (rot_c_out)
  );

  krotate #(.HALF_W(HALF_W)) u_rot_d (
    .din    (rot_d_in),
    .amount (rot_amount),
    .dir    (rot_dir),
    .dout   (rot_d_out)
  );

  // Round datapath: load round 1 on accept, advance on each non-final
  // handshake, hold otherwise; done pulses after the final handshake.
  always_ff @(posedge clk) begin
    // NOTE: the round outputs are architecturally visible and must read zero
    // after reset, so the datapath is reset along with the control state.
    if (rst) begin
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fire && last_round;
      if (accept) begin
        c_q     <= rot_c_out;
        d_q     <= rot_d_out;
        round_q <= RW'(1);
        dec_q   <= bus.decrypt;
      end else if (fire && !last_round) begin
        c_q     <= rot_c_out;
        d_q     <= rot_d_out;
        round_q <= round_q + RW'(1);
      end
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.rk_valid = (state_q == RUN);
  assign bus.rk_c     = c_q;
  assign bus.rk_d     = d_q;
  assign bus.rk_round = round_q;
  assign bus.done     = done_q;

endmodule
